// File: rtl/a_bus_cycle_ctrl.sv
// A-bus access sequencer: classifies accepted accesses, stretches them by speed class, inserts refresh stalls.
// Optional cart-timed MEM_VAR accesses are enabled by defining A_BUS_MEM_VAR_EN.
module a_bus_cycle_ctrl #(
    parameter int FAST_CYC    = 6,
    parameter int SLOW_CYC    = 8,
    parameter int XSLOW_CYC   = 12,
    parameter int REFRESH_CYC = 40,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [23:0]       req_addr,
    input  logic              memsel,
    input  logic              refresh_req,
    output logic              busy,
    output logic              refreshing,
    output logic [1:0]        speed,
    output logic [2:0]        rd_target,
    output logic              done
`ifdef A_BUS_MEM_VAR_EN
    ,
    input  logic [CNT_W-1:0]  var_cyc,
    input  logic              var_sel
`endif
);

    localparam logic [1:0] MEM_FAST  = 2'd0;
    localparam logic [1:0] MEM_SLOW  = 2'd1;
    localparam logic [1:0] MEM_XSLOW = 2'd2;
    localparam logic [1:0] MEM_VAR   = 2'd3;

    localparam logic [2:0] A_RT_CART = 3'd0;
    localparam logic [2:0] A_RT_WRAM = 3'd1;
    localparam logic [2:0] A_RT_JOY  = 3'd2;
    localparam logic [2:0] A_RT_HV   = 3'd3;
    localparam logic [2:0] A_RT_MD   = 3'd4;
    localparam logic [2:0] A_RT_DMA  = 3'd5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_REFRESH = 2'd2;

    localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(REFRESH_CYC - 1);

    function automatic logic [1:0] map_speed(input logic [23:0] a, input logic ms);
        logic [7:0]  b;
        logic [15:0] o;
        b = a[23:16];
        o = a[15:0];
        if (!b[6]) begin
            if (o < 16'h2000)      map_speed = MEM_SLOW;
            else if (o < 16'h4000) map_speed = MEM_FAST;
            else if (o < 16'h4200) map_speed = MEM_XSLOW;
            else if (o < 16'h6000) map_speed = MEM_FAST;
            else if (o < 16'h8000) map_speed = MEM_SLOW;
            else                   map_speed = (b[7] && ms) ? MEM_FAST : MEM_SLOW;
        end else if (!b[7]) begin
            map_speed = MEM_SLOW;
        end else begin
            map_speed = ms ? MEM_FAST : MEM_SLOW;
        end
    endfunction

    // Register decode only applies in system banks; 7E/7F are WRAM regardless of offset.
    function automatic logic [2:0] map_target(input logic [23:0] a);
        logic [7:0]  b;
        logic [15:0] o;
        b = a[23:16];
        o = a[15:0];
        map_target = A_RT_CART;
        if (b == 8'h7E || b == 8'h7F) begin
            map_target = A_RT_WRAM;
        end else if (!b[6]) begin
            if (o < 16'h2000)                             map_target = A_RT_WRAM;
            else if (o == 16'h4016 || o == 16'h4017)      map_target = A_RT_JOY;
            else if (o >= 16'h4218 && o <= 16'h421F)      map_target = A_RT_JOY;
            else if (o >= 16'h4210 && o <= 16'h4213)      map_target = A_RT_HV;
            else if (o >= 16'h4214 && o <= 16'h4217)      map_target = A_RT_MD;
            else if (o >= 16'h4300 && o <= 16'h437F)      map_target = A_RT_DMA;
        end
    endfunction

    function automatic logic [CNT_W-1:0] speed_load(input logic [1:0] sp);
        case (sp)
            MEM_SLOW:  speed_load = CNT_W'(SLOW_CYC - 1);
            MEM_XSLOW: speed_load = CNT_W'(XSLOW_CYC - 1);
            default:   speed_load = CNT_W'(FAST_CYC - 1);
        endcase
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             refresh_pend;
    logic             accept;
    logic [1:0]       acc_speed;
    logic [2:0]       acc_target;
    logic [CNT_W-1:0] acc_load;

    always_comb begin
        acc_target = map_target(req_addr);
        acc_speed  = map_speed(req_addr, memsel);
        acc_load   = speed_load(acc_speed);
`ifdef A_BUS_MEM_VAR_EN
        if (var_sel && acc_target == A_RT_CART) begin
            acc_speed = MEM_VAR;
            acc_load  = (var_cyc == '0) ? '0 : var_cyc - CNT_W'(1);
        end
`endif
    end

    assign done       = (state == ST_ACCESS) && (cnt == '0);
    assign busy       = (state != ST_IDLE);
    assign refreshing = (state == ST_REFRESH);
    assign req_ready  = ((state == ST_IDLE) || done) && !refresh_pend && !refresh_req;
    assign accept     = req_valid && req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            refresh_pend <= 1'b0;
            speed        <= MEM_FAST;
            rd_target    <= A_RT_CART;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (refresh_req || refresh_pend) begin
                        state        <= ST_REFRESH;
                        cnt          <= REF_LOAD;
                        refresh_pend <= 1'b0;
                    end else if (accept) begin
                        state     <= ST_ACCESS;
                        cnt       <= acc_load;
                        speed     <= acc_speed;
                        rd_target <= acc_target;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        if (refresh_req) refresh_pend <= 1'b1;
                    end else if (refresh_pend || refresh_req) begin
                        state        <= ST_REFRESH;
                        cnt          <= REF_LOAD;
                        refresh_pend <= 1'b0;
                    end else if (accept) begin
                        cnt       <= acc_load;
                        speed     <= acc_speed;
                        rd_target <= acc_target;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REFRESH: begin
                    if (refresh_req) refresh_pend <= 1'b1;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    else           state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
